// File: rtl/spi_cmd_slave.sv
// spi_cmd_slave: SPI command receiver with a status reply and a consumer handshake.
// SPI pins are resynchronised into the clk domain and edges are found on the
// synchronised copies, so spi_clk must run at clk/8 or slower.
// Optional build macro SPI_FRAME_ERR_CNT_EN adds err_cnt[7:0], a saturating count
// of short, long and overrun frames. Without the macro the port and counter are absent.
`timescale 1ns/1ps
module spi_cmd_slave #(
    parameter int CMD_BITS    = 51,
    parameter int REPLY_BITS  = 6,
    parameter int SAMPLE_RISE = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  spi_clk,
    input  logic                  spi_cs,
    input  logic                  spi_mosi,
    output logic                  spi_miso,
    input  logic [REPLY_BITS-1:0] status,
    output logic [CMD_BITS-1:0]   data,
    output logic                  dready,
    input  logic                  ack,
`ifdef SPI_FRAME_ERR_CNT_EN
    output logic [7:0]            err_cnt,
`endif
    output logic                  overrun
);

    // The bit counter must be able to hold CMD_BITS+1, which is its saturation value
    localparam int CNT_W  = $clog2(CMD_BITS + 2);
    localparam int RCNT_W = $clog2(REPLY_BITS + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(CMD_BITS + 1);
    localparam logic [CNT_W-1:0]  CNT_LEN  = CNT_W'(CMD_BITS);
    localparam logic [RCNT_W-1:0] RCNT_MAX = RCNT_W'(REPLY_BITS);

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_HOLD         = 2'd1,
        ST_WAIT_ACK_LOW = 2'd2
    } state_t;

    // Synchroniser and edge-detect registers. They reset low, so a chip select
    // that is already low at reset release never looks like a falling edge.
    logic r_sclk_meta, r_sclk_sync, r_sclk_d;
    logic r_cs_meta,   r_cs_sync,   r_cs_d;
    logic r_mosi_meta, r_mosi_sync;

    // Frame tracking
    logic                  r_armed;
    logic                  r_active;
    logic [CNT_W-1:0]      r_bit_cnt;
    logic [CMD_BITS-1:0]   r_shift;
    logic [REPLY_BITS-1:0] r_reply;
    logic [RCNT_W-1:0]     r_reply_cnt;
    logic                  r_miso;

    // Handshake
    state_t                r_state;
    logic [CMD_BITS-1:0]   r_data;
    logic                  r_dready;
    logic                  r_overrun;

    // Edge and frame qualifiers
    logic w_sclk_rise, w_sclk_fall;
    logic w_sample_edge, w_shift_edge;
    logic w_cs_fall, w_cs_rise;
    logic w_in_frame;
    logic w_frame_end;
    logic w_len_ok;
    logic w_accept;
    logic w_drop;

    // Two-flop synchronisers for all SPI inputs plus one extra stage for edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sclk_meta <= 1'b0;
            r_sclk_sync <= 1'b0;
            r_sclk_d    <= 1'b0;
            r_cs_meta   <= 1'b0;
            r_cs_sync   <= 1'b0;
            r_cs_d      <= 1'b0;
            r_mosi_meta <= 1'b0;
            r_mosi_sync <= 1'b0;
        end else begin
            r_sclk_meta <= spi_clk;
            r_sclk_sync <= r_sclk_meta;
            r_sclk_d    <= r_sclk_sync;
            r_cs_meta   <= spi_cs;
            r_cs_sync   <= r_cs_meta;
            r_cs_d      <= r_cs_sync;
            r_mosi_meta <= spi_mosi;
            r_mosi_sync <= r_mosi_meta;
        end
    end

    // Edge decode on the synchronised copies, and frame-level qualifiers
    always_comb begin
        w_sclk_rise   = r_sclk_sync & ~r_sclk_d;
        w_sclk_fall   = ~r_sclk_sync & r_sclk_d;
        if (SAMPLE_RISE != 0) begin
            w_sample_edge = w_sclk_rise;
            w_shift_edge  = w_sclk_fall;
        end else begin
            w_sample_edge = w_sclk_fall;
            w_shift_edge  = w_sclk_rise;
        end
        w_cs_fall   = r_cs_d & ~r_cs_sync;
        w_cs_rise   = ~r_cs_d & r_cs_sync;
        w_in_frame  = r_active & ~r_cs_sync;
        w_frame_end = w_cs_rise & r_active;
        w_len_ok    = (r_bit_cnt == CNT_LEN);
        w_accept    = w_frame_end & w_len_ok & (r_state == ST_IDLE);
        w_drop      = w_frame_end & ~w_accept;
    end

    // Arm only after chip select has been seen high, so a frame already in
    // progress at reset release is ignored until the next clean falling edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_armed <= 1'b0;
        end else if (r_cs_sync && r_cs_d) begin
            r_armed <= 1'b1;
        end else begin
            r_armed <= r_armed;
        end
    end

    // Frame receive: command shift-in, bit count, and status reply shift-out
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_active    <= 1'b0;
            r_bit_cnt   <= {CNT_W{1'b0}};
            r_shift     <= {CMD_BITS{1'b0}};
            r_reply     <= {REPLY_BITS{1'b0}};
            r_reply_cnt <= {RCNT_W{1'b0}};
        end else if (w_cs_fall && r_armed) begin
            r_active    <= 1'b1;
            r_bit_cnt   <= {CNT_W{1'b0}};
            r_shift     <= {CMD_BITS{1'b0}};
            r_reply     <= status;
            r_reply_cnt <= {RCNT_W{1'b0}};
        end else if (w_cs_rise) begin
            r_active    <= 1'b0;
        end else if (w_in_frame) begin
            if (w_sample_edge) begin
                r_shift <= {r_shift[CMD_BITS-2:0], r_mosi_sync};
                if (r_bit_cnt != CNT_MAX) begin
                    r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                end
            end
            if (w_shift_edge) begin
                r_reply <= r_reply << 1;
                if (r_reply_cnt != RCNT_MAX) begin
                    r_reply_cnt <= r_reply_cnt + RCNT_W'(1);
                end
            end
        end
    end

    // MISO is the reply MSB during a frame until the reply is exhausted, else low
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_miso <= 1'b0;
        end else if (w_in_frame && (r_reply_cnt != RCNT_MAX)) begin
            r_miso <= r_reply[REPLY_BITS-1];
        end else begin
            r_miso <= 1'b0;
        end
    end

    // Handshake FSM: latch accepted frames, hold dready until ack, flag overruns
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_data    <= {CMD_BITS{1'b0}};
            r_dready  <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            // A well-formed frame that arrives while the previous one is still
            // being handed over is dropped and remembered until reset
            if (w_frame_end && w_len_ok && (r_state != ST_IDLE)) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_data   <= r_shift;
                        r_dready <= 1'b1;
                        r_state  <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (ack) begin
                        r_dready <= 1'b0;
                        r_state  <= ST_WAIT_ACK_LOW;
                    end
                end
                ST_WAIT_ACK_LOW: begin
                    if (!ack) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_dready <= 1'b0;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef SPI_FRAME_ERR_CNT_EN
    logic [7:0] r_err_cnt;

    // Saturating count of short, long and overrun frames
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err_cnt <= 8'd0;
        end else if (w_drop && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end else begin
            r_err_cnt <= r_err_cnt;
        end
    end

    assign err_cnt = r_err_cnt;
`endif

    assign spi_miso = r_miso;
    assign data     = r_data;
    assign dready   = r_dready;
    assign overrun  = r_overrun;

endmodule

// File: tb/tb_spi_cmd_slave.sv
// Bench for spi_cmd_slave. Two instances share every input: one samples on the
// rising spi_clk edge, the other sees the inverted clock and samples on the
// falling edge, so both must produce identical results for each frame.
`timescale 1ns/1ps
module tb_spi_cmd_slave;
    localparam int CMD_BITS   = 51;
    localparam int REPLY_BITS = 6;

    logic clk = 1'b0;
    logic rst;
    logic spi_clk;
    logic spi_clk_n;
    logic spi_cs;
    logic spi_mosi;
    logic ack;
    logic [REPLY_BITS-1:0] status;

    logic                spi_miso_r, spi_miso_f;
    logic [CMD_BITS-1:0] data_r, data_f;
    logic                dready_r, dready_f;
    logic                overrun_r, overrun_f;
`ifdef SPI_FRAME_ERR_CNT_EN
    logic [7:0]          err_cnt_r, err_cnt_f;
    int                  exp_err = 0;
`endif

    int n_vec = 0;
    int n_err = 0;

    logic [CMD_BITS-1:0] exp_q[$];
    logic                miso_q[$];
    logic [CMD_BITS-1:0] exp_data = '0;

    assign spi_clk_n = ~spi_clk;

    always #5 clk = ~clk;

    spi_cmd_slave #(.CMD_BITS(CMD_BITS), .REPLY_BITS(REPLY_BITS), .SAMPLE_RISE(1)) dut_r (
        .clk(clk), .rst(rst), .spi_clk(spi_clk), .spi_cs(spi_cs), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso_r), .status(status), .data(data_r), .dready(dready_r), .ack(ack),
`ifdef SPI_FRAME_ERR_CNT_EN
        .err_cnt(err_cnt_r),
`endif
        .overrun(overrun_r)
    );

    spi_cmd_slave #(.CMD_BITS(CMD_BITS), .REPLY_BITS(REPLY_BITS), .SAMPLE_RISE(0)) dut_f (
        .clk(clk), .rst(rst), .spi_clk(spi_clk_n), .spi_cs(spi_cs), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso_f), .status(status), .data(data_f), .dready(dready_f), .ack(ack),
`ifdef SPI_FRAME_ERR_CNT_EN
        .err_cnt(err_cnt_f),
`endif
        .overrun(overrun_f)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cs_begin();
        @(negedge clk);
        spi_cs = 1'b0;
        #80;
    endtask

    task automatic cs_end();
        #60;
        spi_cs = 1'b1;
    endtask

    // Drives nbits of val MSB first; checks MISO before each sample edge
    task automatic spi_bits(input int nbits, input logic [63:0] val, input bit reply_on);
        logic e;
        for (int i = 0; i < nbits; i++) begin
            spi_mosi = val[nbits-1-i];
            if (reply_on && i < REPLY_BITS) miso_q.push_back(status[REPLY_BITS-1-i]);
            else miso_q.push_back(1'b0);
            #60;
            e = miso_q.pop_front();
            n_vec++;
            if (spi_miso_r !== e || spi_miso_f !== e) begin
                n_err++;
                $display("FAIL miso bit %0d: got %b/%b expected %b", i, spi_miso_r, spi_miso_f, e);
            end
            spi_clk = ~spi_clk;
            #60;
            spi_clk = ~spi_clk;
        end
    endtask

    // Waits at most 4 clocks after cs rise for dready, then checks data against the scoreboard
    task automatic collect_frame(input string name);
        bit seen = 1'b0;
        logic [CMD_BITS-1:0] e;
        for (int k = 0; k < 4 && !seen; k++) begin
            @(negedge clk);
            if (dready_r === 1'b1 && dready_f === 1'b1) seen = 1'b1;
        end
        n_vec++;
        if (!seen) begin
            n_err++;
            $display("FAIL %s dready: got %b/%b expected 1 within 4 clk", name, dready_r, dready_f);
        end
        e = exp_q.pop_front();
        exp_data = e;
        n_vec++;
        if (data_r !== e || data_f !== e) begin
            n_err++;
            $display("FAIL %s data: got %h/%h expected %h", name, data_r, data_f, e);
        end
    endtask

    // Checks that a frame was not accepted: dready stays low and data is unchanged
    task automatic expect_rejected(input string name, input logic exp_dready);
        bit bad = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (dready_r !== exp_dready || dready_f !== exp_dready) bad = 1'b1;
        end
        n_vec++;
        if (bad) begin
            n_err++;
            $display("FAIL %s dready: got %b/%b expected %b", name, dready_r, dready_f, exp_dready);
        end
        n_vec++;
        if (data_r !== exp_data || data_f !== exp_data) begin
            n_err++;
            $display("FAIL %s data: got %h/%h expected %h", name, data_r, data_f, exp_data);
        end
    endtask

    task automatic do_ack(input string name);
        @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        n_vec++;
        if (dready_r !== 1'b0 || dready_f !== 1'b0) begin
            n_err++;
            $display("FAIL %s ack drop: got %b/%b expected 0", name, dready_r, dready_f);
        end
        ack = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0; spi_clk = 1'b0; spi_cs = 1'b1; spi_mosi = 1'b0; ack = 1'b0; status = '0;
        #12;
        n_vec++;
        if (data_r !== '0 || data_f !== '0 || dready_r !== 1'b0 || dready_f !== 1'b0 ||
            spi_miso_r !== 1'b0 || spi_miso_f !== 1'b0 || overrun_r !== 1'b0 || overrun_f !== 1'b0) begin
            n_err++;
            $display("FAIL reset outputs: got data %h dready %b miso %b overrun %b expected all 0",
                     data_r, dready_r, spi_miso_r, overrun_r);
        end
`ifdef SPI_FRAME_ERR_CNT_EN
        n_vec++;
        if (err_cnt_r !== 8'd0 || err_cnt_f !== 8'd0) begin
            n_err++;
            $display("FAIL reset err_cnt: got %0d/%0d expected 0", err_cnt_r, err_cnt_f);
        end
`endif
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_basic_frame();
        logic [63:0] v;
        v = 64'h5_A5A5_A5A5_A5A5;
        status = 6'b101101;
        cs_begin();
        spi_bits(CMD_BITS, v, 1'b1);
        exp_q.push_back(v[CMD_BITS-1:0]);
        cs_end();
        collect_frame("basic");
        n_vec++;
        if (spi_miso_r !== 1'b0 || spi_miso_f !== 1'b0 || overrun_r !== 1'b0) begin
            n_err++;
            $display("FAIL basic idle: got miso %b/%b overrun %b expected 0", spi_miso_r, spi_miso_f, overrun_r);
        end
    endtask

    task automatic test_handshake();
        bit dropped = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (dready_r !== 1'b1 || dready_f !== 1'b1) dropped = 1'b1;
        end
        n_vec++;
        if (dropped) begin
            n_err++;
            $display("FAIL hold dready: got %b/%b expected 1 for 100 clk", dready_r, dready_f);
        end
        do_ack("handshake");
    endtask

    task automatic test_bad_lengths();
        logic [63:0] v;
        status = 6'b110001;
        v = {$urandom, $urandom};
        cs_begin();
        spi_bits(CMD_BITS - 1, v, 1'b1);
        cs_end();
        expect_rejected("short", 1'b0);
        v = {$urandom, $urandom};
        cs_begin();
        spi_bits(CMD_BITS + 1, v, 1'b1);
        cs_end();
        expect_rejected("long", 1'b0);
`ifdef SPI_FRAME_ERR_CNT_EN
        exp_err += 2;
        n_vec++;
        if (err_cnt_r !== 8'(exp_err) || err_cnt_f !== 8'(exp_err)) begin
            n_err++;
            $display("FAIL bad_len err_cnt: got %0d/%0d expected %0d", err_cnt_r, err_cnt_f, exp_err);
        end
`endif
    endtask

    task automatic test_overrun();
        logic [63:0] a, b;
        status = 6'b010011;
        a = {$urandom, $urandom};
        b = ~a;
        cs_begin();
        spi_bits(CMD_BITS, a, 1'b1);
        exp_q.push_back(a[CMD_BITS-1:0]);
        cs_end();
        collect_frame("frame_a");
        cs_begin();
        spi_bits(CMD_BITS, b, 1'b1);
        cs_end();
        expect_rejected("hold_drop", 1'b1);
        n_vec++;
        if (overrun_r !== 1'b1 || overrun_f !== 1'b1) begin
            n_err++;
            $display("FAIL overrun set: got %b/%b expected 1", overrun_r, overrun_f);
        end
        // Ack and keep it high so the next frame ends in the wait-for-ack-low state
        @(negedge clk);
        ack = 1'b1;
        @(negedge clk);
        cs_begin();
        spi_bits(CMD_BITS, b, 1'b1);
        cs_end();
        expect_rejected("wait_drop", 1'b0);
        ack = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if (overrun_r !== 1'b1 || overrun_f !== 1'b1 || dready_r !== 1'b0) begin
            n_err++;
            $display("FAIL overrun sticky: got %b/%b dready %b expected 1 and 0", overrun_r, overrun_f, dready_r);
        end
`ifdef SPI_FRAME_ERR_CNT_EN
        exp_err += 2;
        n_vec++;
        if (err_cnt_r !== 8'(exp_err) || err_cnt_f !== 8'(exp_err)) begin
            n_err++;
            $display("FAIL overrun err_cnt: got %0d/%0d expected %0d", err_cnt_r, err_cnt_f, exp_err);
        end
`endif
    endtask

    task automatic test_reset_midframe();
        logic [63:0] v;
        status = 6'b100110;
        v = {$urandom, $urandom};
        cs_begin();
        spi_bits(20, v >> 31, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        #20;
        n_vec++;
        if (dready_r !== 1'b0 || data_r !== '0 || data_f !== '0 || overrun_r !== 1'b0 || overrun_f !== 1'b0) begin
            n_err++;
            $display("FAIL midreset outputs: got dready %b data %h overrun %b/%b expected 0",
                     dready_r, data_r, overrun_r, overrun_f);
        end
        exp_data = '0;
`ifdef SPI_FRAME_ERR_CNT_EN
        exp_err = 0;
`endif
        rst = 1'b1;
        spi_bits(31, v, 1'b0);
        cs_end();
        expect_rejected("after_reset", 1'b0);
`ifdef SPI_FRAME_ERR_CNT_EN
        n_vec++;
        if (err_cnt_r !== 8'd0 || err_cnt_f !== 8'd0) begin
            n_err++;
            $display("FAIL midreset err_cnt: got %0d/%0d expected 0", err_cnt_r, err_cnt_f);
        end
`endif
        status = 6'b011010;
        v = {$urandom, $urandom};
        cs_begin();
        spi_bits(CMD_BITS, v, 1'b1);
        exp_q.push_back(v[CMD_BITS-1:0]);
        cs_end();
        collect_frame("post_reset");
        do_ack("post_reset");
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_handshake();
        test_bad_lengths();
        test_overrun();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/spi_cmd_slave.md
SPI_CMD_SLAVE -- requirements
Module: spi_cmd_slave

Interface
REQ-001 SHALL have parameter CMD_BITS, default 51, command frame length in bits.
REQ-002 SHALL have parameter REPLY_BITS, default 6, status reply length in bits.
REQ-003 SHALL have parameter SAMPLE_RISE, default 1; 1 samples MOSI on SCLK rising edge, 0 on falling.
REQ-004 SHALL have port clk  input  1  single system clock; all logic in this domain.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port spi_clk  input  1  host SPI clock, asynchronous to clk.
REQ-007 SHALL have port spi_cs  input  1  host chip select, active-low.
REQ-008 SHALL have port spi_mosi  input  1  host data in, MSB first.
REQ-009 SHALL have port spi_miso  output  1  reply data, MSB first.
REQ-010 SHALL have port status  input  REPLY_BITS  reply word, e.g. PLL lock flags.
REQ-011 SHALL have port data  output  CMD_BITS  last valid command word.
REQ-012 SHALL have port dready  output  1  data valid, held until acknowledged.
REQ-013 SHALL have port ack  input  1  consumer acknowledge.
REQ-014 SHALL have port overrun  output  1  sticky flag: valid frame dropped due to pending handshake.

Function
REQ-015 SHALL pass spi_clk, spi_cs, spi_mosi through 2-FF synchronizers; edges detected on synchronized values; spi_clk SHALL be at most clk/8.
REQ-016 SHALL, on synchronized spi_cs falling edge, clear bit counter, clear shift register, load reply register with status snapshot.
REQ-017 SHALL, on each sample edge while spi_cs low, shift spi_mosi into shift register LSB, previous bits toward MSB, and increment bit counter, saturating at CMD_BITS+1.
REQ-018 SHALL, on each opposite edge while spi_cs low, shift reply register left; spi_miso = reply MSB while spi_cs low, 0 after REPLY_BITS bits shifted and while spi_cs high.
REQ-019 SHALL, on synchronized spi_cs rising edge, treat frame valid only if bit counter equals exactly CMD_BITS; short or long frames discarded, data unchanged.
REQ-020 SHALL implement handshake FSM states IDLE, HOLD, WAIT_ACK_LOW.
REQ-021 IDLE: valid frame end -> data latched, dready=1 next clk, go HOLD; dready rises within 4 clk of raw spi_cs rising.
REQ-022 HOLD: ack=1 -> dready=0 next clk, go WAIT_ACK_LOW; dready never drops without ack.
REQ-023 WAIT_ACK_LOW: ack=0 -> go IDLE.
REQ-024 SHALL, on valid frame end in HOLD or WAIT_ACK_LOW, drop frame, keep data stable, set overrun=1.
REQ-025 overrun SHALL clear only on reset.
REQ-026 Valid frame end and ack=0 in the same WAIT_ACK_LOW cycle SHALL count as overrun; new frame not accepted.
REQ-027 SHALL ignore spi_clk edges while spi_cs high.

Reset
REQ-028 SHALL asynchronously force on rst=0: data=0, dready=0, spi_miso=0, overrun=0, counter=0, FSM IDLE.
REQ-029 SHALL, after rst release with spi_cs already low, ignore the frame in progress until a spi_cs rising then falling edge occurs.
REQ-030 SHALL, on reset mid-frame, discard the partial frame; no dready pulse.

Configuration
REQ-031 With SPI_FRAME_ERR_CNT_EN defined: SHALL add output err_cnt[7:0], incremented on each short, long or overrun frame, saturating at 255, reset to 0.
REQ-032 Without SPI_FRAME_ERR_CNT_EN: err_cnt port and counter SHALL be absent; all other behaviour identical.

Verification
REQ-033 51-bit frame 0x5_A5A5_A5A5_A5A5 with status=6'b101101 -> data=0x5A5A5A5A5A5A5, dready=1 within 4 clk of cs rise; MISO returns 101101 then 0.
REQ-034 dready=1, ack held 0 for 100 clk -> dready stays 1; ack=1 -> dready=0 next clk; ack=0 -> IDLE.
REQ-035 50-bit and 52-bit frames -> no dready, data unchanged, err_cnt increments by 2 when SPI_FRAME_ERR_CNT_EN defined.
REQ-036 Second valid frame sent before ack -> data keeps first value, overrun=1 sticky until rst=0.
REQ-037 rst=0 asserted after 20 bits, released with cs low, remaining 31 bits sent -> no dready; next full frame -> accepted normally.
REQ-038 SAMPLE_RISE=0, same frame as REQ-033 -> identical data and reply.
